// File: rtl/array_mult_seq.sv
// array_mult_seq: sequential radix-2^DIGIT shift-add multiplier, unsigned or two's-complement,
// with valid/ready handshakes on operands and product.
module array_mult_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p
);
    localparam int N  = WIDTH / DIGIT;
    localparam int AW = 2 * WIDTH + 2;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 4 || WIDTH % 2 != 0 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
            $error("array_mult_seq: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next;

    logic [AW-1:0]    acc, mc, add, sum;
    logic [WIDTH-1:0] mb;
    logic [CW-1:0]    cnt;
    logic             tc_r, last;

    assign last = cnt == LAST;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next      = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        next = state == IDLE ? (in_valid ? BUSY : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) :
                               (out_ready ? IDLE : DONE);
    end

    // The multiplier's top bit carries negative weight in signed mode, so its row is subtracted.
    always_comb begin
        add = '0;
        for (int k = 0; k < DIGIT; k++)
            add = !mb[k] ? add : (tc_r && last && k == DIGIT - 1) ? add - (mc << k) : add + (mc << k);
    end

    assign sum = acc + add;

    always_ff @(posedge clk) begin
        if (rst) begin
            p    <= '0;
            acc  <= '0;
            mc   <= '0;
            mb   <= '0;
            cnt  <= '0;
            tc_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            acc  <= '0;
            mc   <= {{(AW - WIDTH){tc & a[WIDTH-1]}}, a};
            mb   <= b;
            cnt  <= '0;
            tc_r <= tc;
        end else if (state == BUSY) begin
            acc <= sum;
            mc  <= mc << DIGIT;
            mb  <= mb >> DIGIT;
            cnt <= cnt + 1'b1;
            if (last) p <= sum[2*WIDTH-1:0];
        end
    end
endmodule
